red_pitaya_fads_mc: RTL and testbench

Multi-channel successor to the single-channel FADS sorter. It detects droplets on a selectable gate channel and tracks the per-channel peak on all NCH ADC channels during each droplet. A droplet is positive only if every enabled channel's peak and the droplet width fall inside their windows; positive droplets fire a delayed sort pulse toward the ASG/HV path. Droplet records go to a read-pop logger FIFO on the system bus.

---
 rtl/red_pitaya_fads_mc.sv | 246 ++++++++++++++++++++++++
 tb/tb_red_pitaya_fads_mc.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/red_pitaya_fads_mc.sv
// Multi-channel FADS droplet sorter. It detects droplets on a gate channel, checks per-channel peak
// windows, fires a delayed sort pulse and keeps a read-pop droplet logger on the system bus.
module red_pitaya_fads_mc #(
    parameter int NCH  = 2,
    parameter int DWT  = 14,
    parameter int CW   = 32,
    parameter int LOGD = 10
) (
    input  logic               adc_clk_i,
    input  logic               adc_rstn_i,
    input  logic [NCH*DWT-1:0] adc_i,
    output logic               sort_trig_o,
    output logic               busy_o,
    input  logic [31:0]        sys_addr,
    input  logic [31:0]        sys_wdata,
    input  logic               sys_wen,
    input  logic               sys_ren,
    output logic [31:0]        sys_rdata,
    output logic               sys_err,
    output logic               sys_ack
);
    localparam int DEPTH = 1 << LOGD;
    localparam int WW    = 32 - DWT;
    localparam logic [CW-1:0]   C_ONE    = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]   C_ONES   = {CW{1'b1}};
    localparam logic [CW-1:0]   WSAT     = CW'((64'd1 << WW) - 64'd1);
    localparam logic [LOGD-1:0] P_ONE    = {{(LOGD-1){1'b0}}, 1'b1};
    localparam logic [LOGD:0]   N_ONE    = {{LOGD{1'b0}}, 1'b1};
    localparam logic [LOGD:0]   CNT_FULL = (LOGD+1)'(DEPTH);
    localparam logic [2:0] S_IDLE = 3'd0, S_ACQ = 3'd1, S_EVAL = 3'd2, S_DELAY = 3'd3, S_SORT = 3'd4;

    logic [2:0]            state_q, state_d;
    logic [CW-1:0]         width_q, width_d, dcnt_q, dcnt_d, scnt_q, scnt_d;
    logic signed [DWT-1:0] peak_q [NCH];
    logic signed [DWT-1:0] peak_d [NCH];
    logic                  trig_q, trig_d, busy_q, busy_d, ack_q, ack_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  enable_q, enable_d;
    logic [1:0]            gate_ch_q, gate_ch_d;
    logic [NCH-1:0]        ch_en_q, ch_en_d;
    logic signed [DWT-1:0] min_thr_q, min_thr_d;
    logic signed [DWT-1:0] low_thr_q [NCH];
    logic signed [DWT-1:0] low_thr_d [NCH];
    logic signed [DWT-1:0] high_thr_q [NCH];
    logic signed [DWT-1:0] high_thr_d [NCH];
    logic [CW-1:0]         width_low_q, width_low_d, width_high_q, width_high_d;
    logic [CW-1:0]         sort_delay_q, sort_delay_d, sort_dur_q, sort_dur_d;
    logic [CW-1:0]         droplets_q, droplets_d, positives_q, positives_d;
    logic [CW-1:0]         missed_q, missed_d, ovf_q, ovf_d;
    logic [LOGD-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LOGD:0]         count_q, count_d;
    logic [31:0]           mem_q [DEPTH];

    logic signed [DWT-1:0] x_s [NCH];
    logic signed [DWT-1:0] gate_x_s, gate_peak_s;
    logic                  gate_hi_s, ch_ok_s, pos_s, clear_s, pop_s, push_s, push_ok_s, mem_we_s;
    logic [WW-1:0]         width_sat_s;
    logic [31:0]           log_word_s;
    logic [19:0]           addr_s;
    logic                  unused_s;

    assign unused_s    = ^sys_addr[31:20];
    assign addr_s      = sys_addr[19:0];
    assign sort_trig_o = trig_q;
    assign busy_o      = busy_q;
    assign sys_rdata   = rdata_q;
    assign sys_ack     = ack_q;
    assign sys_err     = 1'b0;

    // Split samples, select the gate channel and evaluate the droplet acceptance windows.
    always_comb begin
        gate_x_s    = {DWT{1'b0}};
        gate_peak_s = {DWT{1'b0}};
        ch_ok_s     = 1'b1;
        for (int k = 0; k < NCH; k++) begin
            x_s[k]      = adc_i[k*DWT +: DWT];
            gate_x_s    = (gate_ch_q == 2'(k)) ? x_s[k] : gate_x_s;
            gate_peak_s = (gate_ch_q == 2'(k)) ? peak_q[k] : gate_peak_s;
            ch_ok_s     = ch_ok_s & (~ch_en_q[k] | ((peak_q[k] >= low_thr_q[k]) & (peak_q[k] < high_thr_q[k])));
        end
        gate_hi_s   = (gate_x_s >= min_thr_q);
        pos_s       = (width_q >= width_low_q) && (width_q < width_high_q) && (|ch_en_q) && ch_ok_s;
        width_sat_s = (width_q > WSAT) ? {WW{1'b1}} : width_q[WW-1:0];
        log_word_s  = {width_sat_s, gate_peak_s};
        clear_s     = sys_wen && (addr_s == 20'h000) && sys_wdata[1];
        pop_s       = sys_ren && (addr_s == 20'h200) && (count_q != {(LOGD+1){1'b0}}) && !clear_s;
    end

    // Droplet state machine, event counters and logger pointers; clear overrides everything.
    always_comb begin
        state_d = state_q; width_d = width_q; dcnt_d = dcnt_q; scnt_d = scnt_q;
        trig_d = 1'b0; push_s = 1'b0;
        droplets_d = droplets_q; positives_d = positives_q; missed_d = missed_q; ovf_d = ovf_q;
        for (int k = 0; k < NCH; k++) peak_d[k] = peak_q[k];
        case (state_q)
            S_IDLE: begin
                if (enable_q && gate_hi_s) begin
                    state_d = S_ACQ;
                    width_d = C_ONE;
                    for (int k = 0; k < NCH; k++) peak_d[k] = x_s[k];
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACQ: begin
                if (!gate_hi_s) begin
                    state_d = S_EVAL;
                end else begin
                    width_d = (width_q == C_ONES) ? width_q : width_q + C_ONE;
                    for (int k = 0; k < NCH; k++) peak_d[k] = (x_s[k] > peak_q[k]) ? x_s[k] : peak_q[k];
                end
            end
            S_EVAL: begin
                droplets_d = droplets_q + C_ONE;
                push_s     = 1'b1;
                if (pos_s) begin
                    positives_d = positives_q + C_ONE;
                    state_d     = S_DELAY;
                    dcnt_d      = {CW{1'b0}};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DELAY: begin
                if (dcnt_q == sort_delay_q) begin
                    state_d = S_SORT;
                    scnt_d  = {CW{1'b0}};
                end else begin
                    dcnt_d = dcnt_q + C_ONE;
                end
            end
            S_SORT: begin
                if (scnt_q >= sort_dur_q) begin
                    state_d  = S_IDLE;
                    missed_d = gate_hi_s ? missed_q + C_ONE : missed_q;
                end else begin
                    trig_d = 1'b1;
                    scnt_d = scnt_q + C_ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A full logger still accepts the word when the head is popped in the same cycle.
        push_ok_s = push_s && ((count_q != CNT_FULL) || pop_s);
        ovf_d     = (push_s && !push_ok_s) ? ovf_q + C_ONE : ovf_q;
        wr_ptr_d  = push_ok_s ? wr_ptr_q + P_ONE : wr_ptr_q;
        rd_ptr_d  = pop_s ? rd_ptr_q + P_ONE : rd_ptr_q;
        case ({push_ok_s, pop_s})
            2'b10:   count_d = count_q + N_ONE;
            2'b01:   count_d = count_q - N_ONE;
            default: count_d = count_q;
        endcase
        if (clear_s) begin
            state_d = S_IDLE; trig_d = 1'b0; mem_we_s = 1'b0;
            droplets_d = {CW{1'b0}}; positives_d = {CW{1'b0}}; missed_d = {CW{1'b0}}; ovf_d = {CW{1'b0}};
            wr_ptr_d = {LOGD{1'b0}}; rd_ptr_d = {LOGD{1'b0}}; count_d = {(LOGD+1){1'b0}};
        end else begin
            mem_we_s = push_ok_s;
        end
        busy_d = (state_d != S_IDLE);
    end

    // Configuration writes and registered bus read data / acknowledge.
    always_comb begin
        enable_d = enable_q; gate_ch_d = gate_ch_q; ch_en_d = ch_en_q; min_thr_d = min_thr_q;
        width_low_d = width_low_q; width_high_d = width_high_q;
        sort_delay_d = sort_delay_q; sort_dur_d = sort_dur_q;
        rdata_d = 32'd0;
        ack_d   = sys_wen | sys_ren;
        if (sys_wen) begin
            case (addr_s)
                20'h000: begin enable_d = sys_wdata[0]; gate_ch_d = sys_wdata[9:8]; end
                20'h004: ch_en_d      = sys_wdata[NCH-1:0];
                20'h008: min_thr_d    = sys_wdata[DWT-1:0];
                20'h040: width_low_d  = CW'(sys_wdata);
                20'h044: width_high_d = CW'(sys_wdata);
                20'h048: sort_delay_d = CW'(sys_wdata);
                20'h04C: sort_dur_d   = CW'(sys_wdata);
                default: ;
            endcase
        end else begin
            enable_d = enable_q;
        end
        if (sys_ren) begin
            case (addr_s)
                20'h000: rdata_d = {22'd0, gate_ch_q, 7'd0, enable_q};
                20'h004: rdata_d = 32'(ch_en_q);
                20'h008: rdata_d = 32'(min_thr_q);
                20'h040: rdata_d = 32'(width_low_q);
                20'h044: rdata_d = 32'(width_high_q);
                20'h048: rdata_d = 32'(sort_delay_q);
                20'h04C: rdata_d = 32'(sort_dur_q);
                20'h100: rdata_d = 32'(droplets_q);
                20'h104: rdata_d = 32'(positives_q);
                20'h108: rdata_d = 32'(missed_q);
                20'h10C: rdata_d = 32'(ovf_q);
                20'h110: rdata_d = 32'(count_q);
                20'h200: rdata_d = pop_s ? mem_q[rd_ptr_q] : 32'd0;
                default: rdata_d = 32'd0;
            endcase
        end else begin
            rdata_d = 32'd0;
        end
        for (int k = 0; k < NCH; k++) begin
            low_thr_d[k]  = (sys_wen && addr_s == 20'h010 + 20'(8*k)) ? sys_wdata[DWT-1:0] : low_thr_q[k];
            high_thr_d[k] = (sys_wen && addr_s == 20'h014 + 20'(8*k)) ? sys_wdata[DWT-1:0] : high_thr_q[k];
            rdata_d = (sys_ren && addr_s == 20'h010 + 20'(8*k)) ? 32'(low_thr_q[k]) : rdata_d;
            rdata_d = (sys_ren && addr_s == 20'h014 + 20'(8*k)) ? 32'(high_thr_q[k]) : rdata_d;
        end
    end

    // State, configuration, counters and bus registers.
    always_ff @(posedge adc_clk_i) begin
        if (!adc_rstn_i) begin
            state_q <= S_IDLE; width_q <= {CW{1'b0}}; dcnt_q <= {CW{1'b0}}; scnt_q <= {CW{1'b0}};
            trig_q <= 1'b0; busy_q <= 1'b0; ack_q <= 1'b0; rdata_q <= 32'd0;
            enable_q <= 1'b0; gate_ch_q <= 2'd0; ch_en_q <= {{(NCH-1){1'b0}}, 1'b1};
            min_thr_q <= DWT'(15);
            for (int k = 0; k < NCH; k++) begin
                peak_q[k] <= {DWT{1'b0}}; low_thr_q[k] <= DWT'(16); high_thr_q[k] <= DWT'(255);
            end
            width_low_q <= C_ONE; width_high_q <= C_ONES;
            sort_delay_q <= CW'(32'd31250); sort_dur_q <= CW'(32'd125000);
            droplets_q <= {CW{1'b0}}; positives_q <= {CW{1'b0}}; missed_q <= {CW{1'b0}}; ovf_q <= {CW{1'b0}};
            wr_ptr_q <= {LOGD{1'b0}}; rd_ptr_q <= {LOGD{1'b0}}; count_q <= {(LOGD+1){1'b0}};
        end else begin
            state_q <= state_d; width_q <= width_d; dcnt_q <= dcnt_d; scnt_q <= scnt_d;
            trig_q <= trig_d; busy_q <= busy_d; ack_q <= ack_d; rdata_q <= rdata_d;
            enable_q <= enable_d; gate_ch_q <= gate_ch_d; ch_en_q <= ch_en_d; min_thr_q <= min_thr_d;
            for (int k = 0; k < NCH; k++) begin
                peak_q[k] <= peak_d[k]; low_thr_q[k] <= low_thr_d[k]; high_thr_q[k] <= high_thr_d[k];
            end
            width_low_q <= width_low_d; width_high_q <= width_high_d;
            sort_delay_q <= sort_delay_d; sort_dur_q <= sort_dur_d;
            droplets_q <= droplets_d; positives_q <= positives_d; missed_q <= missed_d; ovf_q <= ovf_d;
            wr_ptr_q <= wr_ptr_d; rd_ptr_q <= rd_ptr_d; count_q <= count_d;
        end
    end

    // Logger storage; contents are only meaningful below the write pointer, so no reset.
    always_ff @(posedge adc_clk_i) begin
        if (mem_we_s) begin
            mem_q[wr_ptr_q] <= log_word_s;
        end
    end
endmodule

// File: tb/tb_red_pitaya_fads_mc.sv
// Self-checking bench for red_pitaya_fads_mc: directed scenarios plus randomized droplets
// checked against a droplet-level reference model.
module tb_red_pitaya_fads_mc;
    localparam int NCH = 2, DWT = 14, CW = 32, LOGD = 2;

    logic               clk = 1'b0;
    logic               rstn;
    logic [NCH*DWT-1:0] adc;
    logic               trig, busy, wen, ren, err, ack;
    logic [31:0]        addr, wdata, rdata;
    int total = 0, bad = 0;

    int     cfg_lo [NCH];
    int     cfg_hi [NCH];
    int     cfg_en, cfg_gate, cfg_delay, cfg_dur;
    longint cfg_wlo, cfg_whi;

    always #5 clk = ~clk;

    red_pitaya_fads_mc #(.NCH(NCH), .DWT(DWT), .CW(CW), .LOGD(LOGD)) dut (
        .adc_clk_i(clk), .adc_rstn_i(rstn), .adc_i(adc), .sort_trig_o(trig), .busy_o(busy),
        .sys_addr(addr), .sys_wdata(wdata), .sys_wen(wen), .sys_ren(ren),
        .sys_rdata(rdata), .sys_err(err), .sys_ack(ack));

    // Droplet outcome from the acceptance rules: width window plus every enabled channel's peak window.
    function automatic bit model_pos(input int len, input int pk0, input int pk1);
        int  pk [NCH];
        bit  ok;
        bit  any;
        pk[0] = pk0; pk[1] = pk1;
        ok  = (longint'(len) >= cfg_wlo) && (longint'(len) < cfg_whi);
        any = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            if (cfg_en[k]) begin
                any = 1'b1;
                if (!(pk[k] >= cfg_lo[k] && pk[k] < cfg_hi[k])) ok = 1'b0;
            end
        end
        return ok && any;
    endfunction

    function automatic logic [31:0] model_word(input int len, input int pk);
        int w;
        w = (len > 262143) ? 262143 : len;
        return (32'(w) << 14) | (32'(pk) & 32'h3FFF);
    endfunction

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk); addr = a; wdata = d; wen = 1'b1;
        @(posedge clk); #1; wen = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic k);
        @(negedge clk); addr = a; ren = 1'b1;
        @(posedge clk); #1; d = rdata; k = ack; ren = 1'b0;
    endtask

    task automatic set_ch(input int k, input int v);
        adc[k*DWT +: DWT] = v[DWT-1:0];
    endtask

    task automatic configure(input int en, input int gate, input longint wlo, input longint whi,
                             input int dly, input int dur);
        cfg_en = en; cfg_gate = gate; cfg_wlo = wlo; cfg_whi = whi; cfg_delay = dly; cfg_dur = dur;
        bus_write(32'h000, {22'd0, 2'(gate), 7'd0, 1'b1});
        bus_write(32'h004, 32'(en));
        bus_write(32'h040, 32'(wlo));
        bus_write(32'h044, 32'(whi));
        bus_write(32'h048, 32'(dly));
        bus_write(32'h04C, 32'(dur));
    endtask

    task automatic set_thr(input int k, input int lo, input int hi);
        cfg_lo[k] = lo; cfg_hi[k] = hi;
        bus_write(32'h010 + 32'(8*k), 32'(lo));
        bus_write(32'h014 + 32'(8*k), 32'(hi));
    endtask

    task automatic do_clear();
        bus_write(32'h000, {22'd0, 2'(cfg_gate), 6'd0, 2'b11});
    endtask

    // Constant-level droplet of len samples; returns on the negedge where the gate drops.
    task automatic run_droplet(input int len, input int v0, input int v1);
        @(negedge clk); set_ch(0, v0); set_ch(1, v1);
        repeat (len) @(negedge clk);
        adc = '0;
    endtask

    // Watch sort_trig_o for a bounded window after a gate fall: first-rise latency and high-cycle count.
    task automatic measure(input int budget, output int lat, output int hi);
        lat = -1; hi = 0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (trig) begin
                if (lat < 0) lat = i - 1;
                hi++;
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] d; logic k;
        logic [31:0] ra [16] = '{32'h000, 32'h004, 32'h008, 32'h010, 32'h014, 32'h018, 32'h01C, 32'h040,
                                 32'h044, 32'h048, 32'h04C, 32'h100, 32'h104, 32'h108, 32'h10C, 32'h110};
        logic [31:0] re [16] = '{32'd0, 32'd1, 32'd15, 32'd16, 32'd255, 32'd16, 32'd255, 32'd1,
                                 32'hFFFF_FFFF, 32'd31250, 32'd125000, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        rstn = 1'b0; wen = 1'b0; ren = 1'b0; addr = '0; wdata = '0; adc = '0;
        repeat (2) @(posedge clk);
        @(negedge clk); rstn = 1'b1;
        total++;
        if (trig !== 1'b0 || busy !== 1'b0 || ack !== 1'b0 || rdata !== 32'd0 || err !== 1'b0) begin
            bad++; $display("FAIL reset_outputs trig=%b busy=%b ack=%b rdata=%h err=%b want 0", trig, busy, ack, rdata, err);
        end
        for (int i = 0; i < 16; i++) begin
            bus_read(ra[i], d, k);
            total++;
            if (d !== re[i] || k !== 1'b1) begin
                bad++; $display("FAIL reset_reg addr=%h got=%h ack=%b want=%h ack=1", ra[i], d, k, re[i]);
            end
        end
        bus_write(32'h010, 32'h0000_3FFB);
        bus_read(32'h010, d, k);
        total++;
        if (d !== 32'hFFFF_FFFB) begin bad++; $display("FAIL thr_signext got=%h want=fffffffb", d); end
        bus_write(32'h010, 32'd16);
        bus_read(32'h300, d, k);
        total++;
        if (d !== 32'd0 || k !== 1'b1) begin bad++; $display("FAIL unmapped got=%h ack=%b want 0/1", d, k); end
    endtask

    task automatic test_positive();
        logic [31:0] d; logic k; int lat, hi;
        configure(3, 0, 1, 64'hFFFF_FFFF, 10, 20);
        set_thr(0, 16, 255); set_thr(1, 16, 255);
        run_droplet(50, 100, 200);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL busy_acq got=%b want=1", busy); end
        measure(60, lat, hi);
        total++;
        if (!model_pos(50, 100, 200) || lat !== cfg_delay + 3) begin bad++; $display("FAIL pos_latency got=%0d want=%0d", lat, cfg_delay + 3); end
        total++;
        if (hi !== cfg_dur) begin bad++; $display("FAIL pos_width got=%0d want=%0d", hi, cfg_dur); end
        bus_read(32'h104, d, k);
        total++;
        if (d !== 32'd1) begin bad++; $display("FAIL pos_positives got=%0d want=1", d); end
        bus_read(32'h200, d, k);
        total++;
        if (d !== model_word(50, 100)) begin bad++; $display("FAIL pos_fifo got=%h want=%h", d, model_word(50, 100)); end
        bus_read(32'h110, d, k);
        total++;
        if (d !== 32'd0 || busy !== 1'b0) begin bad++; $display("FAIL pos_after count=%0d busy=%b want 0/0", d, busy); end
    endtask

    task automatic test_veto();
        logic [31:0] d; logic k; int lat, hi;
        do_clear();
        run_droplet(50, 100, 300);
        measure(60, lat, hi);
        total++;
        if (hi !== (model_pos(50, 100, 300) ? cfg_dur : 0)) begin bad++; $display("FAIL veto_pulse got=%0d want=0", hi); end
        bus_read(32'h100, d, k);
        total++;
        if (d !== 32'd1) begin bad++; $display("FAIL veto_droplets got=%0d want=1", d); end
        bus_read(32'h104, d, k);
        total++;
        if (d !== 32'd0) begin bad++; $display("FAIL veto_positives got=%0d want=0", d); end
        cfg_en = 1; bus_write(32'h004, 32'd1);
        run_droplet(50, 100, 300);
        measure(60, lat, hi);
        total++;
        if (hi !== (model_pos(50, 100, 300) ? cfg_dur : 0) || lat !== cfg_delay + 3) begin
            bad++; $display("FAIL veto_ch_en1 hi=%0d lat=%0d want=%0d/%0d", hi, lat, cfg_dur, cfg_delay + 3);
        end
        for (int i = 0; i < 2; i++) begin
            bus_read(32'h200, d, k);
            total++;
            if (d !== model_word(50, 100)) begin bad++; $display("FAIL veto_fifo%0d got=%h want=%h", i, d, model_word(50, 100)); end
        end
    endtask

    task automatic test_width();
        logic [31:0] d; logic k; int lat, hi;
        int lens [3] = '{5, 20, 60};
        do_clear();
        configure(3, 0, 10, 40, 10, 20);
        for (int i = 0; i < 3; i++) begin
            run_droplet(lens[i], 100, 200);
            measure(60, lat, hi);
            total++;
            if (hi !== (model_pos(lens[i], 100, 200) ? cfg_dur : 0)) begin
                bad++; $display("FAIL width_len%0d got=%0d want=%0d", lens[i], hi, model_pos(lens[i], 100, 200) ? cfg_dur : 0);
            end
        end
        bus_read(32'h100, d, k);
        total++;
        if (d !== 32'd3) begin bad++; $display("FAIL width_droplets got=%0d want=3", d); end
        bus_read(32'h104, d, k);
        total++;
        if (d !== 32'd1) begin bad++; $display("FAIL width_positives got=%0d want=1", d); end
        for (int i = 0; i < 3; i++) begin
            bus_read(32'h200, d, k);
            total++;
            if (d !== model_word(lens[i], 100)) begin bad++; $display("FAIL width_fifo%0d got=%h want=%h", i, d, model_word(lens[i], 100)); end
        end
        configure(3, 0, 1, 64'hFFFF_FFFF, 10, 20);
    endtask

    task automatic test_fifo();
        logic [31:0] d; logic k;
        logic [31:0] exp_w [5];
        do_clear();
        for (int i = 0; i < 6; i++) begin
            run_droplet(i + 3, 100, 300);
            repeat (4) @(negedge clk);
        end
        bus_read(32'h110, d, k);
        total++;
        if (d !== 32'd4) begin bad++; $display("FAIL fifo_count got=%0d want=4", d); end
        bus_read(32'h10C, d, k);
        total++;
        if (d !== 32'd2) begin bad++; $display("FAIL fifo_overflows got=%0d want=2", d); end
        // Pop lands on the push cycle of the next droplet while the logger is full.
        run_droplet(9, 100, 300);
        bus_read(32'h200, d, k);
        total++;
        if (d !== model_word(3, 100)) begin bad++; $display("FAIL fifo_pushpop got=%h want=%h", d, model_word(3, 100)); end
        repeat (3) @(negedge clk);
        bus_read(32'h10C, d, k);
        total++;
        if (d !== 32'd2) begin bad++; $display("FAIL fifo_pushpop_ovf got=%0d want=2", d); end
        exp_w = '{model_word(4, 100), model_word(5, 100), model_word(6, 100), model_word(9, 100), 32'd0};
        for (int i = 0; i < 5; i++) begin
            bus_read(32'h200, d, k);
            total++;
            if (d !== exp_w[i]) begin bad++; $display("FAIL fifo_pop%0d got=%h want=%h", i, d, exp_w[i]); end
        end
    endtask

    task automatic test_missed();
        logic [31:0] d; logic k; int lat, hi;
        do_clear();
        configure(3, 0, 1, 64'hFFFF_FFFF, 2, 5);
        run_droplet(10, 100, 200);
        repeat (4) @(negedge clk);
        set_ch(0, 100);
        repeat (30) @(negedge clk);
        adc = '0;
        measure(40, lat, hi);
        bus_read(32'h108, d, k);
        total++;
        if (d !== 32'd1) begin bad++; $display("FAIL missed_sorts got=%0d want=1", d); end
    endtask

    task automatic test_clear();
        logic [31:0] d; logic k; int lat, hi; bit seen;
        do_clear();
        configure(3, 0, 1, 64'hFFFF_FFFF, 10, 20);
        run_droplet(50, 100, 200);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = trig;
        end
        total++;
        if (!seen) begin bad++; $display("FAIL clear_wait_sort trig=0 want=1 within 40 cycles"); end
        do_clear();
        total++;
        if (trig !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL clear_now trig=%b busy=%b want 0/0", trig, busy); end
        bus_read(32'h104, d, k);
        total++;
        if (d !== 32'd0) begin bad++; $display("FAIL clear_positives got=%0d want=0", d); end
        bus_read(32'h110, d, k);
        total++;
        if (d !== 32'd0) begin bad++; $display("FAIL clear_count got=%0d want=0", d); end
        run_droplet(50, 100, 200);
        measure(60, lat, hi);
        total++;
        if (lat !== cfg_delay + 3 || hi !== cfg_dur) begin
            bad++; $display("FAIL clear_next lat=%0d hi=%0d want=%0d/%0d", lat, hi, cfg_delay + 3, cfg_dur);
        end
        bus_read(32'h104, d, k);
        total++;
        if (d !== 32'd1) begin bad++; $display("FAIL clear_next_pos got=%0d want=1", d); end
    endtask

    task automatic test_random();
        logic [31:0] d; logic k; int lat, hi, len, v, npos, lo;
        int pk [NCH];
        bit pos;
        do_clear();
        npos = 0;
        for (int it = 0; it < 10; it++) begin
            for (int c = 0; c < NCH; c++) begin
                lo = int'($urandom_range(10, 150));
                set_thr(c, lo, lo + int'($urandom_range(1, 200)));
            end
            configure(int'($urandom_range(0, 3)), int'($urandom_range(0, 1)), longint'($urandom_range(1, 10)),
                      longint'($urandom_range(5, 40)), int'($urandom_range(0, 5)), int'($urandom_range(0, 6)));
            len = int'($urandom_range(1, 30));
            @(negedge clk);
            for (int c = 0; c < len; c++) begin
                for (int ch = 0; ch < NCH; ch++) begin
                    v = (ch == cfg_gate) ? int'($urandom_range(15, 350)) : int'($urandom_range(0, 700)) - 350;
                    set_ch(ch, v);
                    if (c == 0 || v > pk[ch]) pk[ch] = v;
                end
                @(negedge clk);
            end
            adc = '0;
            pos = model_pos(len, pk[0], pk[1]);
            if (pos) npos++;
            measure(cfg_delay + cfg_dur + 20, lat, hi);
            total++;
            if (hi !== (pos ? cfg_dur : 0) || (pos && cfg_dur > 0 && lat !== cfg_delay + 3)) begin
                bad++; $display("FAIL rand%0d hi=%0d lat=%0d want=%0d/%0d", it, hi, lat, pos ? cfg_dur : 0, cfg_delay + 3);
            end
            bus_read(32'h200, d, k);
            total++;
            if (d !== model_word(len, pk[cfg_gate])) begin
                bad++; $display("FAIL rand%0d_word got=%h want=%h", it, d, model_word(len, pk[cfg_gate]));
            end
        end
        bus_read(32'h100, d, k);
        total++;
        if (d !== 32'd10) begin bad++; $display("FAIL rand_droplets got=%0d want=10", d); end
        bus_read(32'h104, d, k);
        total++;
        if (d !== 32'(npos)) begin bad++; $display("FAIL rand_positives got=%0d want=%0d", d, npos); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_positive();
        test_veto();
        test_width();
        test_fifo();
        test_missed();
        test_clear();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
